// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder checker slice.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } checker_state_t;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int unsigned count_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/adder_checker_if.sv
// Stimulus/observation bundle between an adder bench and adder_checker.
// First-mismatch capture signals exist only with ADDER_CHECKER_FIRST_ERR_EN.
interface adder_checker_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_CHECKS = 16
) ();
  localparam int unsigned CW = count_w(NUM_CHECKS);

  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CW-1:0]    check_count;
  logic [CW-1:0]    err_count;
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic [WIDTH-1:0] first_err_sum;
`endif

  modport master (
    output start, in_valid, a, b, sum,
    input  busy, done, pass, check_count, err_count
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    , input first_err_valid, first_err_a, first_err_b, first_err_sum
`endif
  );

  modport slave (
    input  start, in_valid, a, b, sum,
    output busy, done, pass, check_count, err_count
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    , output first_err_valid, first_err_a, first_err_b, first_err_sum
`endif
  );

endinterface

// File: rtl/adder_delay_line.sv
// DEPTH-stage valid+data shift register with synchronous clear of the valids.
module adder_delay_line #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);
  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] dat [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) vld[i] <= vld[i-1];
    end
  end

  // Payload needs no reset: it is only consumed alongside a set valid.
  always_ff @(posedge clk) begin
    dat[0] <= in_data;
    for (int i = 1; i < int'(DEPTH); i++) dat[i] <= dat[i-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/adder_checker.sv
// Self-checking monitor for a registered adder: predicts a+b, delays it by
// LATENCY and compares against sum. Optional ADDER_CHECKER_FIRST_ERR_EN
// captures operands and observed sum of the first mismatch in a run.
module adder_checker
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned NUM_CHECKS = 16
) (
  input logic             clk,
  input logic             rstn,
  adder_checker_if.slave  bus
);
  localparam int unsigned CW = count_w(NUM_CHECKS);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  localparam int unsigned DW = 3 * WIDTH;
`else
  localparam int unsigned DW = WIDTH;
`endif

  checker_state_t state;
  logic           busy, done, pass;
  logic [CW-1:0]  check_count, err_count;

  logic [WIDTH-1:0] exp_c;
  logic [DW-1:0]    dl_in_c;
  logic             dl_valid;
  logic [DW-1:0]    dl_data;
  logic             start_acc_c, cmp_c, mism_c;

  assign exp_c       = bus.a + bus.b;
  assign start_acc_c = bus.start && (state != RUN);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  assign dl_in_c = {bus.a, bus.b, exp_c};
`else
  assign dl_in_c = exp_c;
`endif

  adder_delay_line #(.DEPTH(LATENCY), .DATA_W(DW)) u_dl (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (start_acc_c),
    .in_valid  (bus.in_valid),
    .in_data   (dl_in_c),
    .out_valid (dl_valid),
    .out_data  (dl_data)
  );

  assign cmp_c  = dl_valid && (state == RUN);
  assign mism_c = cmp_c && (bus.sum != dl_data[WIDTH-1:0]);

`ifdef ADDER_CHECKER_FIRST_ERR_EN
  logic             fe_valid;
  logic [WIDTH-1:0] fe_a, fe_b, fe_sum;

  // First mismatch of the run is latched and held until start or reset.
  always_ff @(posedge clk) begin
    if (!rstn || start_acc_c) begin
      fe_valid <= 1'b0;
      fe_a     <= '0;
      fe_b     <= '0;
      fe_sum   <= '0;
    end else if (mism_c && !fe_valid) begin
      fe_valid <= 1'b1;
      fe_a     <= dl_data[3*WIDTH-1:2*WIDTH];
      fe_b     <= dl_data[2*WIDTH-1:WIDTH];
      fe_sum   <= bus.sum;
    end
  end

  assign bus.first_err_valid = fe_valid;
  assign bus.first_err_a     = fe_a;
  assign bus.first_err_b     = fe_b;
  assign bus.first_err_sum   = fe_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            check_count <= '0;
            err_count   <= '0;
          end
        end
        RUN: begin
          if (cmp_c) begin
            check_count <= check_count + CW'(1);
            if (mism_c) err_count <= err_count + CW'(1);
            // Last comparison of the run: verdict includes this one.
            if (check_count == CW'(NUM_CHECKS - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !mism_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass        = pass;
  assign bus.check_count = check_count;
  assign bus.err_count   = err_count;

endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker: two instances (2 checks/latency 1 and
// 4 checks/latency 2) each fed by a bench-side registered adder model.
module tb_adder_checker;
  logic clk;
  logic rstn;
  logic fault_b;
  logic [7:0] pb1;
  int checks;
  int errors;

  adder_checker_if #(.WIDTH(8), .NUM_CHECKS(2)) ia ();
  adder_checker_if #(.WIDTH(8), .NUM_CHECKS(4)) ib ();

  adder_checker #(.WIDTH(8), .LATENCY(1), .NUM_CHECKS(2)) dut_a (
    .clk (clk), .rstn (rstn), .bus (ia)
  );
  adder_checker #(.WIDTH(8), .LATENCY(2), .NUM_CHECKS(4)) dut_b (
    .clk (clk), .rstn (rstn), .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: one-stage for dut_a, two-stage with fault injection for dut_b.
  always_ff @(posedge clk) ia.sum <= ia.a + ia.b;
  always_ff @(posedge clk) begin
    pb1    <= fault_b ? 8'd0 : ib.a + ib.b;
    ib.sum <= pb1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; fault_b = 1'b0;
    ia.start = 1'b0; ia.in_valid = 1'b0; ia.a = '0; ia.b = '0;
    ib.start = 1'b0; ib.in_valid = 1'b0; ib.a = '0; ib.b = '0;
    tick(); tick();

    check("rst_a_busy", 32'(ia.busy), 0);
    check("rst_a_done", 32'(ia.done), 0);
    check("rst_b_busy", 32'(ib.busy), 0);
    check("rst_b_done", 32'(ib.done), 0);
    check("rst_b_pass", 32'(ib.pass), 0);
    check("rst_b_cnt",  32'(ib.check_count), 0);
    check("rst_b_err",  32'(ib.err_count), 0);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    check("rst_b_fev", 32'(ib.first_err_valid), 0);
`endif
    rstn = 1'b1;
    tick();

    // dut_a basic run: 15+10, 25+30
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    check("a_start_busy", 32'(ia.busy), 1);
    check("a_start_cnt",  32'(ia.check_count), 0);
    ia.in_valid = 1'b1; ia.a = 8'd15; ia.b = 8'd10; tick();
    check("a_cnt_e1", 32'(ia.check_count), 0);
    ia.a = 8'd25; ia.b = 8'd30; tick();
    check("a_cnt_e2",  32'(ia.check_count), 1);
    check("a_done_e2", 32'(ia.done), 0);
    ia.in_valid = 1'b0; tick();
    check("a_done", 32'(ia.done), 1);
    check("a_pass", 32'(ia.pass), 1);
    check("a_busy", 32'(ia.busy), 0);
    check("a_cnt",  32'(ia.check_count), 2);
    check("a_err",  32'(ia.err_count), 0);

    // dut_a overflow run from DONE: 200+100 wraps to 44
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    check("ov_done_clr", 32'(ia.done), 0);
    check("ov_cnt_clr",  32'(ia.check_count), 0);
    check("ov_busy",     32'(ia.busy), 1);
    ia.in_valid = 1'b1; ia.a = 8'd200; ia.b = 8'd100; tick();
    check("ov_model_sum", 32'(ia.sum), 44);
    ia.a = 8'd1; ia.b = 8'd2; tick();
    ia.in_valid = 1'b0; tick();
    check("ov_done", 32'(ia.done), 1);
    check("ov_pass", 32'(ia.pass), 1);
    check("ov_err",  32'(ia.err_count), 0);

    // dut_b fault run: second of four samples has sum forced to 0
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    ib.in_valid = 1'b1; ib.a = 8'd1; ib.b = 8'd2; tick();
    ib.a = 8'd3; ib.b = 8'd4; fault_b = 1'b1; tick();
    fault_b = 1'b0; ib.a = 8'd5; ib.b = 8'd6; tick();
    ib.a = 8'd7; ib.b = 8'd8; tick();
    ib.in_valid = 1'b0; tick();
    check("f_cnt_e5",  32'(ib.check_count), 3);
    check("f_err_e5",  32'(ib.err_count), 1);
    check("f_done_e5", 32'(ib.done), 0);
    tick();
    check("f_done", 32'(ib.done), 1);
    check("f_pass", 32'(ib.pass), 0);
    check("f_busy", 32'(ib.busy), 0);
    check("f_cnt",  32'(ib.check_count), 4);
    check("f_err",  32'(ib.err_count), 1);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    check("f_fev",  32'(ib.first_err_valid), 1);
    check("f_fea",  32'(ib.first_err_a), 3);
    check("f_feb",  32'(ib.first_err_b), 4);
    check("f_fes",  32'(ib.first_err_sum), 0);
`endif

    // dut_b gap run with mid-run start and a sample pending at run end
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    check("g_done_clr", 32'(ib.done), 0);
    check("g_err_clr",  32'(ib.err_count), 0);
`ifdef ADDER_CHECKER_FIRST_ERR_EN
    check("g_fev_clr", 32'(ib.first_err_valid), 0);
`endif
    ib.in_valid = 1'b1; ib.a = 8'd10; ib.b = 8'd20; tick();
    ib.in_valid = 1'b0; tick();
    check("g_cnt_e2", 32'(ib.check_count), 0);
    tick(); tick();
    check("g_cnt_gap", 32'(ib.check_count), 1);
    ib.in_valid = 1'b1; ib.a = 8'd30; ib.b = 8'd40; tick();
    ib.a = 8'd50; ib.b = 8'd60; tick();
    ib.a = 8'd70; ib.b = 8'd80; ib.start = 1'b1; tick(); ib.start = 1'b0;
    check("g_cnt_e7",  32'(ib.check_count), 2);
    check("g_busy_e7", 32'(ib.busy), 1);
    ib.a = 8'd90; ib.b = 8'd1; tick();
    ib.in_valid = 1'b0;
    check("g_cnt_e8",  32'(ib.check_count), 3);
    check("g_done_e8", 32'(ib.done), 0);
    tick();
    check("g_done", 32'(ib.done), 1);
    check("g_cnt",  32'(ib.check_count), 4);
    check("g_pass", 32'(ib.pass), 1);
    check("g_busy", 32'(ib.busy), 0);
    tick();
    check("g_cnt_hold", 32'(ib.check_count), 4);
    check("g_err_hold", 32'(ib.err_count), 0);

    // dut_b reset mid-run, then start with a discarded start-cycle sample
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    ib.in_valid = 1'b1; ib.a = 8'd1; ib.b = 8'd1; tick();
    ib.a = 8'd2; ib.b = 8'd2; tick();
    ib.a = 8'd3; ib.b = 8'd3; rstn = 1'b0; tick();
    check("r_busy", 32'(ib.busy), 0);
    check("r_done", 32'(ib.done), 0);
    check("r_pass", 32'(ib.pass), 0);
    check("r_cnt",  32'(ib.check_count), 0);
    check("r_err",  32'(ib.err_count), 0);
    rstn = 1'b1;
    ib.a = 8'd7; ib.b = 8'd7; ib.start = 1'b1; tick();
    ib.start = 1'b0; ib.in_valid = 1'b0;
    tick(); tick(); tick();
    check("r_cnt_after", 32'(ib.check_count), 0);
    check("r_busy_after", 32'(ib.busy), 1);
    check("r_a_idle", 32'(ia.done), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
# adder_checker

Synthesizable self-checking monitor on the output side of the registered `adder`. It samples the operands presented to the adder, predicts the sum, delays the prediction by the adder's pipeline latency and compares it with the adder's `sum` output. It counts checks and mismatches over a programmed run and reports pass/fail, so adder benches and on-chip BIST get a verdict without per-test expected values.

## Interface
- `WIDTH`, 8, operand/sum width; must match the adder.
- `LATENCY`, 1, cycles from operands sampled to `sum` valid; ≥1.
- `NUM_CHECKS`, 16, comparisons per run; ≥1.
- `clk`  input  1  clock, all logic on rising edge.
- `rstn`  input  1  reset, synchronous, active-low.
- `start`  input  1  begin a run (pulse).
- `in_valid`  input  1  `a`/`b` this cycle form a sample to check.
- `a`  input  WIDTH  operand driven to the adder.
- `b`  input  WIDTH  operand driven to the adder.
- `sum`  input  WIDTH  adder output.
- `busy`  output  1  run in progress.
- `done`  output  1  run complete, held until next `start` or reset.
- `pass`  output  1  valid with `done`: 1 = zero mismatches.
- `check_count`  output  $clog2(NUM_CHECKS+1)  comparisons in current run.
- `err_count`  output  $clog2(NUM_CHECKS+1)  mismatches in current run.

## Operation
- Reset (`rstn`=0 at edge): state IDLE; all outputs 0; delay-line valids cleared.
- Prediction: `exp = (a + b) mod 2^WIDTH`, carry discarded; computed only when `in_valid`=1.
- Delay line: LATENCY stages of {valid, exp}, shifts every cycle in all states.
- Comparison occurs when delay-line output valid=1 and state RUN: `check_count`++; if `sum` != delayed `exp`, `err_count`++.
- FSM:
  - IDLE: `start` → RUN; clear counters and delay-line valids.
  - RUN: `busy`=1; when the comparison making `check_count`==NUM_CHECKS occurs → DONE.
  - DONE: `done`=1, `pass` = (`err_count`==0); `start` → RUN with same clears as IDLE.
- `start` while RUN: ignored.
- Samples with `in_valid`=1 in the `start` cycle are discarded (delay line cleared that cycle); first counted sample is the one after `start`.
- Comparisons pending in the delay line when the run ends are dropped, never counted.
- `in_valid` gaps: no comparison, counters hold; run length is counted in checks, not cycles.
- Counters cannot exceed NUM_CHECKS; no wrap.

## Timing
- Sample at edge t (`in_valid`=1) is compared against `sum` sampled at edge t+LATENCY.
- Counters update at the edge after the comparison cycle.
- `done`, `pass`, `busy`=0 become visible the cycle after the NUM_CHECKS-th comparison; `busy` and `done` never both 1.
- `start` at edge t: `busy`=1, counters=0, `done`=0 from cycle t+1.
- Reset mid-run: at the reset edge all outputs return to 0 and state IDLE; no partial verdict.

## Configuration
- `ADDER_CHECKER_FIRST_ERR_EN` defined: extra outputs `first_err_valid` (1), `first_err_a`, `first_err_b`, `first_err_sum` (WIDTH each) capture operands and observed sum of the first mismatch in a run; operands travel through the delay line alongside `exp`; cleared by reset and `start`, held until then.
- Undefined: ports and storage absent; delay line carries only {valid, exp}.

## Structure
- `adder_pkg`: `checker_state_t` enum (IDLE, RUN, DONE), count-width helper function.
- Sub-module `adder_delay_line` (parameters DEPTH, DATA_W; synchronous clear input): LATENCY-deep valid+data shift register, reused by other checkers.

## Test plan
- NUM_CHECKS=2, LATENCY=1, correct adder: `start`, then 15+10, 25+30 → sums 25, 55 compared; `done`=1, `pass`=1, `check_count`=2, `err_count`=0.
- Overflow: 200+100 → expected 44; correct adder passes, no false error.
- Fault: force `sum`=0 for one sample of 4 (NUM_CHECKS=4) → `err_count`=1, `pass`=0; with macro, `first_err_*` holds that sample's a, b, 0.
- `in_valid` low 3 cycles between samples → no counts during gap; `done` only after NUM_CHECKS valid samples.
- `start` pulse mid-run → ignored, counters continue; `start` in DONE → counters clear, new run.
- `rstn`=0 mid-run for one edge → all outputs 0 next cycle, IDLE; stale delay-line samples never counted in a subsequent run.
